// File: rtl/cpuid_server.sv
// ----------------------------------------------------------------------------
// cpuid_server
//   Multi-channel CPUID responder. NUM_CH requesters share one leaf/subleaf
//   decoder behind a round-robin arbiter. Each transaction walks
//   IDLE -> LOOKUP -> RESP, so at most one request is served every 3 cycles.
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   req_valid_i    per-channel request valid
//   req_ready_o    per-channel request accept (one-hot or zero, IDLE only)
//   req_leaf_i     leaf per channel, channel c at [32c +: 32]
//   req_subleaf_i  subleaf per channel, same packing
//   rsp_valid_o    per-channel response valid (one-hot or zero, RESP only)
//   rsp_ready_i    per-channel response accept (only the granted bit matters)
//   rsp_data_o     {w3,w2,w1,w0}, qualified by rsp_valid_o
//   rsp_known_o    1 = leaf/subleaf implemented, 0 = zeros returned
//   busy_o         high in LOOKUP and RESP
//
// Build option
//   CARBON_CPUID_ERRATA_EN  enables the ERRATA0 leaf (w0 = ERRATA_MASK) and
//                           raises the advertised max standard leaf to it.
// ----------------------------------------------------------------------------
module cpuid_server #(
    parameter int          NUM_CH      = 2,
    parameter int          CORE_COUNT  = 1,
    parameter int          VECTOR_BITS = 128,
    parameter logic [31:0] ERRATA_MASK = 32'h0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_CH-1:0]     req_valid_i,
    output logic [NUM_CH-1:0]     req_ready_o,
    input  logic [NUM_CH*32-1:0]  req_leaf_i,
    input  logic [NUM_CH*32-1:0]  req_subleaf_i,
    output logic [NUM_CH-1:0]     rsp_valid_o,
    input  logic [NUM_CH-1:0]     rsp_ready_i,
    output logic [127:0]          rsp_data_o,
    output logic                  rsp_known_o,
    output logic                  busy_o
);
    localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    // Leaf numbers and field codes, mirroring carbon_arch_pkg.
    localparam logic [31:0] LEAF_VENDOR    = 32'h0000_0000;
    localparam logic [31:0] LEAF_ID        = 32'h0000_0001;
    localparam logic [31:0] LEAF_TIERS     = 32'h0000_0002;
    localparam logic [31:0] LEAF_FEATURES0 = 32'h0000_0003;
    localparam logic [31:0] LEAF_TOPOLOGY  = 32'h0000_0004;
    localparam logic [31:0] LEAF_ERRATA0   = 32'h0000_0005;
    localparam logic [7:0]  LADDER_Z80     = 8'h01;
    localparam logic [7:0]  P7_Z480        = 8'h07;
    localparam logic [7:0]  LADDER_AMD_FPU = 8'h02;
    localparam logic [7:0]  P0_AM9511      = 8'h01;
    localparam logic [31:0] FEAT0_MASK     = 32'h0000_003F; // MODE_SWITCH|CSR_NAMESPACE|FABRIC|CPUID|CAPS|Z480_NATIVE_64

`ifdef CARBON_CPUID_ERRATA_EN
    localparam logic [15:0] MAX_STD_LEAF = LEAF_ERRATA0[15:0];
`else
    localparam logic [15:0] MAX_STD_LEAF = LEAF_TOPOLOGY[15:0];
`endif

    localparam logic [31:0] CC32 = 32'(CORE_COUNT);
    localparam logic [31:0] VB32 = 32'(VECTOR_BITS);

    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_RESP} state_e;

    state_e         state_q, state_d;
    logic [PW-1:0]  rr_q, rr_d, gnt_q, gnt_d, pick;
    logic [31:0]    leaf_q, leaf_d, sub_q, sub_d, pick_leaf, pick_sub;
    logic [127:0]   data_q, data_d, dec_data;
    logic           known_q, known_d, dec_known, found;

    // Round-robin pick: first valid channel at or above rr_q, wrapping.
    always_comb begin
        int idx;
        idx       = 0;
        found     = 1'b0;
        pick      = '0;
        pick_leaf = '0;
        pick_sub  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!found && req_valid_i[PW'(idx)]) begin
                found     = 1'b1;
                pick      = PW'(idx);
                pick_leaf = req_leaf_i[idx*32 +: 32];
                pick_sub  = req_subleaf_i[idx*32 +: 32];
            end
        end
    end

    // Leaf decoder on the latched request.
    always_comb begin
        logic [31:0] w0, w1, w2, w3;
        w0 = '0; w1 = '0; w2 = '0; w3 = '0;
        dec_known = 1'b1;
        case (leaf_q)
            LEAF_VENDOR: begin
                w0 = {16'd1, MAX_STD_LEAF};
                w1 = 32'h4252_4143;
                w2 = 32'h5A2D_4E4F;
                w3 = 32'h2030_3834;
            end
            LEAF_ID: begin
                w0 = 32'h0107_9000;
                w1 = 32'h0000_001F;
            end
            LEAF_TIERS: begin
                w0 = {8'h0, P7_Z480, P7_Z480, LADDER_Z80};
                w1 = {8'h0, P0_AM9511, P0_AM9511, LADDER_AMD_FPU};
            end
            LEAF_FEATURES0: w0 = FEAT0_MASK;
            LEAF_TOPOLOGY: begin
                if (sub_q == 32'd0) begin
                    w0 = {16'd1, CC32[15:0]};
                    w1 = {16'd64, VB32[15:0]};
                end else if (sub_q <= CC32) begin
                    // Subleaf k describes core k-1, one thread each.
                    w0 = sub_q - 32'd1;
                    w1 = 32'd1;
                end else begin
                    dec_known = 1'b0;
                end
            end
`ifdef CARBON_CPUID_ERRATA_EN
            LEAF_ERRATA0: w0 = ERRATA_MASK;
`else
            LEAF_ERRATA0: dec_known = 1'b0;
`endif
            default: dec_known = 1'b0;
        endcase
        dec_data = {w3, w2, w1, w0};
    end

    // FSM: state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FSM: next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (found) state_d = S_LOOKUP;
            S_LOOKUP: state_d = S_RESP;
            S_RESP:   if (rsp_ready_i[gnt_q]) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM: outputs.
    always_comb begin
        req_ready_o = '0;
        rsp_valid_o = '0;
        busy_o      = (state_q != S_IDLE);
        if (state_q == S_IDLE && found) req_ready_o[pick] = 1'b1;
        if (state_q == S_RESP)          rsp_valid_o[gnt_q] = 1'b1;
    end

    // Datapath next state.
    always_comb begin
        rr_d    = rr_q;
        gnt_d   = gnt_q;
        leaf_d  = leaf_q;
        sub_d   = sub_q;
        data_d  = data_q;
        known_d = known_q;
        case (state_q)
            S_IDLE: if (found) begin
                gnt_d  = pick;
                leaf_d = pick_leaf;
                sub_d  = pick_sub;
            end
            S_LOOKUP: begin
                data_d  = dec_data;
                known_d = dec_known;
            end
            S_RESP: if (rsp_ready_i[gnt_q])
                rr_d = (int'(gnt_q) == NUM_CH - 1) ? '0 : gnt_q + PW'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q    <= '0;
            gnt_q   <= '0;
            leaf_q  <= '0;
            sub_q   <= '0;
            data_q  <= '0;
            known_q <= 1'b0;
        end else begin
            rr_q    <= rr_d;
            gnt_q   <= gnt_d;
            leaf_q  <= leaf_d;
            sub_q   <= sub_d;
            data_q  <= data_d;
            known_q <= known_d;
        end
    end

    assign rsp_data_o  = data_q;
    assign rsp_known_o = known_q;

endmodule

// File: tb/tb_cpuid_server.sv
module tb_cpuid_server;
    localparam int          NCH   = 2;
    localparam int          CC    = 4;
    localparam logic [31:0] EMASK = 32'h0000_0005;

`ifdef CARBON_CPUID_ERRATA_EN
    localparam logic [31:0] MAXSTD = 32'd5;
`else
    localparam logic [31:0] MAXSTD = 32'd4;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [NCH-1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
    logic [NCH*32-1:0] req_leaf, req_subleaf;
    logic [127:0]    rsp_data;
    logic            rsp_known, busy;

    int total = 0;
    int bad   = 0;
    int rr    = 0;   // model of the round-robin pointer

    cpuid_server #(.NUM_CH(NCH), .CORE_COUNT(CC), .VECTOR_BITS(128), .ERRATA_MASK(EMASK)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_leaf_i(req_leaf), .req_subleaf_i(req_subleaf),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_data_o(rsp_data), .rsp_known_o(rsp_known), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Reference answer for a leaf/subleaf, straight from the leaf table.
    function automatic void ref_lookup(input logic [31:0] leaf, input logic [31:0] sub,
                                       output logic [127:0] d, output logic k);
        logic [31:0] w [4];
        w = '{32'h0, 32'h0, 32'h0, 32'h0};
        k = 1'b1;
        if (leaf == 32'd0) begin
            w[0] = 32'h0001_0000 + MAXSTD;
            w[1] = 32'h4252_4143; w[2] = 32'h5A2D_4E4F; w[3] = 32'h2030_3834;
        end else if (leaf == 32'd1) begin
            w[0] = 32'h0107_9000; w[1] = 32'h0000_001F;
        end else if (leaf == 32'd2) begin
            w[0] = 32'h0007_0701; w[1] = 32'h0001_0102;
        end else if (leaf == 32'd3) begin
            w[0] = 32'h0000_003F;
        end else if (leaf == 32'd4) begin
            if (sub == 0) begin
                w[0] = 32'h0001_0000 + CC; w[1] = 32'h0040_0000 + 128;
            end else if (longint'(sub) <= longint'(CC)) begin
                w[0] = sub - 1; w[1] = 1;
            end else k = 1'b0;
        end else if (leaf == 32'd5) begin
`ifdef CARBON_CPUID_ERRATA_EN
            w[0] = EMASK;
`else
            k = 1'b0;
`endif
        end else k = 1'b0;
        d = {w[3], w[2], w[1], w[0]};
    endfunction

    // One full transaction. Called one step after a clock edge with the DUT idle.
    // Requests are presented after edge N; grant at edge N+1; response after N+2.
    task automatic serve(input logic [1:0] vmask, input logic [31:0] l0, input logic [31:0] s0,
                         input logic [31:0] l1, input logic [31:0] s1, input int hold, input string tag);
        int g;
        logic [1:0] oh;
        logic [127:0] ed;
        logic ek;
        g = -1;
        for (int k = 0; k < NCH; k++)
            if (g < 0 && vmask[(rr + k) % NCH]) g = (rr + k) % NCH;
        oh = 2'b01 << g;
        ref_lookup(g == 0 ? l0 : l1, g == 0 ? s0 : s1, ed, ek);
        req_leaf = {l1, l0}; req_subleaf = {s1, s0}; req_valid = vmask;
        #1;
        chk({tag, ".req_ready"}, 128'(req_ready), 128'(oh));
        step();
        req_valid[g] = 1'b0;
        chk({tag, ".lookup_busy"}, 128'(busy), 128'(1'b1));
        chk({tag, ".lookup_rsp_valid"}, 128'(rsp_valid), 128'(0));
        chk({tag, ".lookup_req_ready"}, 128'(req_ready), 128'(0));
        step();
        chk({tag, ".rsp_valid"}, 128'(rsp_valid), 128'(oh));
        chk({tag, ".rsp_data"}, rsp_data, ed);
        chk({tag, ".rsp_known"}, 128'(rsp_known), 128'(ek));
        for (int h = 0; h < hold; h++) begin
            rsp_ready = ~oh;   // only the other channel says ready: must be ignored
            step();
            chk({tag, ".hold_valid"}, 128'(rsp_valid), 128'(oh));
            chk({tag, ".hold_data"}, rsp_data, ed);
            chk({tag, ".hold_known"}, 128'(rsp_known), 128'(ek));
            chk({tag, ".hold_req_ready"}, 128'(req_ready), 128'(0));
        end
        rsp_ready = oh;
        step();
        rsp_ready = '0;
        chk({tag, ".done_valid"}, 128'(rsp_valid), 128'(0));
        chk({tag, ".done_busy"}, 128'(busy), 128'(0));
        rr = (g + 1) % NCH;
    endtask

    function automatic logic [31:0] rnd_leaf();
        int r;
        r = $urandom_range(0, 8);
        if (r <= 5) return 32'(r);
        if (r == 6) return 32'hDEAD_BEEF;
        return $urandom;
    endfunction

    function automatic logic [31:0] rnd_sub();
        return ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 6));
    endfunction

    initial begin
        rst = 1'b1; req_valid = '0; rsp_ready = '0; req_leaf = '0; req_subleaf = '0;
        repeat (3) step();
        rst = 1'b0;
        #1;
        chk("reset.req_ready", 128'(req_ready), 128'(0));
        chk("reset.rsp_valid", 128'(rsp_valid), 128'(0));
        chk("reset.rsp_data", rsp_data, 128'(0));
        chk("reset.rsp_known", 128'(rsp_known), 128'(0));
        chk("reset.busy", 128'(busy), 128'(0));

        // Vendor leaf on ch0, immediate accept.
        serve(2'b01, 32'd0, 32'd0, 32'd0, 32'd0, 0, "vendor");
        // Two-way contention from rr=1 -> ch1 first, then the waiting ch0.
        serve(2'b11, 32'd1, 32'd0, 32'd2, 32'd0, 0, "arb_a");
        serve(2'b01, 32'd1, 32'd0, 32'd2, 32'd0, 0, "arb_b");
        // rr back at ch1's turn? Model decides; both again.
        serve(2'b11, 32'd3, 32'd0, 32'd4, 32'd0, 0, "arb_c");
        serve(2'b11, 32'd3, 32'd0, 32'd4, 32'd0, 0, "arb_d");
        // Topology subleaves, including the boundaries.
        serve(2'b01, 32'd4, 32'd3, 32'd0, 32'd0, 0, "topo_sub3");
        serve(2'b10, 32'd0, 32'd0, 32'd4, 32'd5, 0, "topo_sub5");
        serve(2'b01, 32'd4, 32'd0, 32'd0, 32'd0, 0, "topo_sub0");
        serve(2'b10, 32'd0, 32'd0, 32'd4, 32'd4, 0, "topo_sub4");
        serve(2'b01, 32'd4, 32'hFFFF_FFFF, 32'd0, 32'd0, 0, "topo_submax");
        // Unknown leaf and the optional errata leaf.
        serve(2'b10, 32'd0, 32'd0, 32'hDEAD_BEEF, 32'd0, 0, "unknown");
        serve(2'b01, 32'd5, 32'd0, 32'd0, 32'd0, 0, "errata0");
        // Back-pressure: response held 10 cycles.
        serve(2'b11, 32'd2, 32'd0, 32'd0, 32'd0, 10, "hold10");

        // Reset while in LOOKUP drops the transaction and clears rr.
        if (rr == 0) serve(2'b01, 32'd1, 32'd0, 32'd0, 32'd0, 0, "pre_reset");
        req_leaf = '0; req_subleaf = '0; req_valid = 2'b10;
        step();                       // accept edge -> LOOKUP
        req_valid = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        rr  = 0;
        chk("midrst.rsp_valid", 128'(rsp_valid), 128'(0));
        chk("midrst.busy", 128'(busy), 128'(0));
        chk("midrst.rsp_data", rsp_data, 128'(0));
        for (int i = 0; i < 4; i++) begin
            step();
            chk("midrst.no_answer", 128'(rsp_valid), 128'(0));
        end
        serve(2'b11, 32'd0, 32'd0, 32'd1, 32'd0, 0, "post_reset_rr0");

        // Randomized traffic against the model.
        for (int i = 0; i < 40; i++)
            serve(2'($urandom_range(1, 3)), rnd_leaf(), rnd_sub(), rnd_leaf(), rnd_sub(),
                  $urandom_range(0, 3), "rand");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
